// File: rtl/paro_rampa_parcial_if.sv
// Signal bundle for the soft-stop ramp controller. emergencia exists only when
// EMERGENCY_STOP_EN is defined.
interface paro_rampa_parcial_if;
    // Signalling contract: the command inputs are plain levels, synchronous to clk.
    // They are sampled on every rising edge but only acted on in the states that
    // listen to them. out_* and busy are registered levels. done is a registered
    // single-cycle pulse. state_dbg mirrors the FSM state register.
    logic       marcha;
    logic       paro;
    logic       Rapido;
    logic       Lento;
`ifdef EMERGENCY_STOP_EN
    logic       emergencia;
`endif
    logic       out_100;
    logic       out_50;
    logic       out_30;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

`ifdef EMERGENCY_STOP_EN
    modport master (
        output marcha, paro, Rapido, Lento, emergencia,
        input  out_100, out_50, out_30, busy, done, state_dbg
    );
    modport slave (
        input  marcha, paro, Rapido, Lento, emergencia,
        output out_100, out_50, out_30, busy, done, state_dbg
    );
`else
    modport master (
        output marcha, paro, Rapido, Lento,
        input  out_100, out_50, out_30, busy, done, state_dbg
    );
    modport slave (
        input  marcha, paro, Rapido, Lento,
        output out_100, out_50, out_30, busy, done, state_dbg
    );
`endif
endinterface

// File: rtl/paro_rampa_parcial.sv
// Soft-stop controller: RUN at 100 %, then 50 % -> 30 % -> off with a prescaled dwell.
// Optional EMERGENCY_STOP_EN adds an emergencia input that aborts to IDLE without done.
module paro_rampa_parcial #(
    parameter int PRESCALE     = 4,
    parameter int DWELL_RAPIDO = 2,
    parameter int DWELL_LENTO  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    paro_rampa_parcial_if.slave   bus
);

    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DMAX = (DWELL_RAPIDO > DWELL_LENTO) ? DWELL_RAPIDO : DWELL_LENTO;
    localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

    localparam logic [PW-1:0] PRE_LAST    = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] LAST_RAPIDO = DW'(DWELL_RAPIDO - 1);
    localparam logic [DW-1:0] LAST_LENTO  = DW'(DWELL_LENTO - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP50 = 2'd2,
        STEP30 = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   pre_q;
    logic [DW-1:0]   dwell_q;
    logic            mode_fast;
    logic [DW-1:0]   dwell_last;
    logic            stepping;
    logic            tick;
    logic            step_end;
    logic            emerg;
    logic            mode_fast_sel;

`ifdef EMERGENCY_STOP_EN
    assign emerg = bus.emergencia;
`else
    assign emerg = 1'b0;
`endif

    assign stepping   = (state == STEP50) || (state == STEP30);
    assign tick       = stepping && (pre_q == PRE_LAST);
    assign dwell_last = mode_fast ? LAST_RAPIDO : LAST_LENTO;
    assign step_end   = tick && (dwell_q == dwell_last);

    // Rapido wins over Lento; neither selected falls back to the slow dwell.
    always_comb begin
        mode_fast_sel = 1'b0;
        case ({bus.Rapido, bus.Lento})
            2'b10, 2'b11: mode_fast_sel = 1'b1;
            2'b01:        mode_fast_sel = 1'b0;
            default:      mode_fast_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.marcha && !bus.paro && !emerg)
                    state_next = RUN;
            end
            RUN: begin
                if (emerg)
                    state_next = IDLE;
                else if (bus.paro)
                    state_next = STEP50;
            end
            STEP50: begin
                if (emerg)
                    state_next = IDLE;
                else if (step_end)
                    state_next = STEP30;
            end
            STEP30: begin
                if (emerg || step_end)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Counters restart on every state change so each step begins a fresh dwell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            dwell_q <= '0;
        end else if (state_next != state) begin
            pre_q   <= '0;
            dwell_q <= '0;
        end else if (stepping) begin
            if (tick) begin
                pre_q <= '0;
                if (dwell_q != dwell_last)
                    dwell_q <= dwell_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mode_fast <= 1'b0;
        else if ((state == RUN) && (state_next == STEP50))
            mode_fast <= mode_fast_sel;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_100 <= 1'b0;
            bus.out_50  <= 1'b0;
            bus.out_30  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.out_100 <= (state_next == RUN);
            bus.out_50  <= (state_next == STEP50);
            bus.out_30  <= (state_next == STEP30);
            bus.busy    <= (state_next == STEP50) || (state_next == STEP30);
            bus.done    <= (state == STEP30) && (state_next == IDLE) && !emerg;
        end
    end

    assign bus.state_dbg = state;

endmodule
